// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook timer: FSM state encoding, time width,
// button increments and the saturating time adder.
package cook_timer_pkg;

  localparam int unsigned SEC_W     = 13;
  localparam int unsigned ADD_W     = 7;
  localparam int unsigned ADD_SHORT = 10;
  localparam int unsigned ADD_LONG  = 60;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Adds a button increment to a time value, clamping at limit instead of wrapping.
  function automatic logic [SEC_W-1:0] sat_add(
    input logic [SEC_W-1:0] base,
    input logic [ADD_W-1:0] add,
    input logic [SEC_W-1:0] limit
  );
    logic [SEC_W:0]   sum;
    logic [SEC_W-1:0] res;
    sum = {1'b0, base} + (SEC_W+1)'(add);
    if (sum > {1'b0, limit}) begin
      res = limit;
    end else begin
      res = sum[SEC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts while enabled, holds its phase while paused,
// and returns to zero otherwise.
module sec_tick #(
  parameter int unsigned CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end else if (hold) begin
      r_cnt <= r_cnt;
    end else begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    tick = en && (r_cnt == LAST);
  end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: button-set countdown that runs while heat is on and pulses finish.
// Define COOK_TIMER_ADD_WHILE_RUN_EN to accept presses while running or paused.
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 1000,
  parameter int unsigned MAX_SEC = 5999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_10s,
  input  logic             add_60s,
  input  logic             clear,
  input  logic             heat,
  output logic             finish,
  output logic [SEC_W-1:0] remaining,
  output logic             running,
  output logic             time_set
);

  localparam logic [SEC_W-1:0] SAT_LIM = SEC_W'(MAX_SEC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prev_10;
  logic             r_prev_60;
  logic [SEC_W-1:0] r_remaining;

  logic             w_edge_10;
  logic             w_edge_60;
  logic [ADD_W-1:0] w_add;
  logic             w_accept;
  logic             w_press;
  logic             w_tick;
  logic             w_tick_en;
  logic             w_tick_hold;
  logic [SEC_W-1:0] w_rem_base;
  logic [SEC_W-1:0] w_rem_nxt;

  // Button history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_10 <= 1'b0;
      r_prev_60 <= 1'b0;
    end else begin
      r_prev_10 <= add_10s;
      r_prev_60 <= add_60s;
    end
  end

  always_comb begin
    w_edge_10 = add_10s && !r_prev_10;
    w_edge_60 = add_60s && !r_prev_60;
    w_add     = (w_edge_10 ? ADD_W'(ADD_SHORT) : '0)
              + (w_edge_60 ? ADD_W'(ADD_LONG)  : '0);
  end

  always_comb begin
    w_accept = (r_state == ST_IDLE) || (r_state == ST_SET);
`ifdef COOK_TIMER_ADD_WHILE_RUN_EN
    w_accept = w_accept || (r_state == ST_RUN) || (r_state == ST_PAUSED);
`endif
    w_press  = w_accept && (w_edge_10 || w_edge_60);
  end

  // Clear suppresses the tick and drops the prescaler back to zero
  always_comb begin
    w_tick_en   = (r_state == ST_RUN)    && !clear;
    w_tick_hold = (r_state == ST_PAUSED) && !clear;
  end

  sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_tick_en),
    .hold (w_tick_hold),
    .tick (w_tick)
  );

  // A tick and a press in the same cycle combine as remaining-1+add
  always_comb begin
    w_rem_base = w_tick ? (r_remaining - SEC_W'(1)) : r_remaining;
    w_rem_nxt  = w_press ? sat_add(w_rem_base, w_add, SAT_LIM) : w_rem_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (clear) begin
      r_remaining <= '0;
    end else begin
      r_remaining <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt = ST_SET;
        end else if (heat) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_SET: begin
        if (heat) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A press landing on the final tick keeps the timer alive
        if (w_tick && (r_remaining == SEC_W'(1)) && !w_press) begin
          w_state_nxt = ST_DONE;
        end else if (!heat) begin
          w_state_nxt = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (heat) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    finish    = 1'b0;
    running   = 1'b0;
    time_set  = 1'b0;
    remaining = r_remaining;
    finish    = (r_state == ST_DONE);
    running   = (r_state == ST_RUN);
    time_set  = (r_remaining != '0);
  end

endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 1000, meaning clk cycles per second.
REQ-002 The block SHALL have parameter MAX_SEC, default 5999, meaning the saturation limit for remaining time (99:59).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port add_10s, input, 1 bit: level button; each rising edge adds 10 s.
REQ-006 The block SHALL have port add_60s, input, 1 bit: level button; each rising edge adds 60 s.
REQ-007 The block SHALL have port clear, input, 1 bit: level; while high it zeroes the time and aborts the timer.
REQ-008 The block SHALL have port heat, input, 1 bit: the microwave controller's heat output; the timer runs only while it is high.
REQ-009 The block SHALL have port finish, output, 1 bit: one-cycle pulse that drives the controller's finish input.
REQ-010 The block SHALL have port remaining, output, 13 bits: remaining seconds, unsigned binary.
REQ-011 The block SHALL have port running, output, 1 bit: high when the state is RUN.
REQ-012 The block SHALL have port time_set, output, 1 bit: high when remaining != 0.

Function
REQ-013 States SHALL be IDLE, SET, RUN, PAUSED and DONE.
REQ-014 Button edges SHALL be detected internally against a registered previous value; only a rising edge counts as a press.
REQ-015 A press SHALL add to remaining with saturation at MAX_SEC, never wrapping.
REQ-016 If add_10s and add_60s edges arrive in the same cycle, both SHALL apply: +70 s, saturated.
REQ-017 From IDLE, a press SHALL move to SET with the new time.
REQ-018 In IDLE, heat high SHALL move to DONE, so a zero-time start always ends with a finish pulse.
REQ-019 In SET, heat high SHALL move to RUN.
REQ-020 In RUN, heat low SHALL move to PAUSED; in PAUSED, heat high SHALL return to RUN.
REQ-021 The prescaler SHALL count 0..CLK_HZ-1 only in RUN, hold its value in PAUSED, and clear to 0 in every other state.
REQ-022 A tick SHALL occur in the RUN cycle where the prescaler equals CLK_HZ-1, and remaining SHALL decrement by 1 on that edge.
REQ-023 A tick with remaining==1 SHALL set remaining to 0 and move to DONE.
REQ-024 finish SHALL be high exactly during the one DONE cycle; DONE SHALL always go to IDLE next.
REQ-025 clear high SHALL force IDLE, remaining 0 and prescaler 0 from any state, with no finish pulse.
REQ-026 clear SHALL take priority over presses, ticks and heat in the same cycle.
REQ-027 Presses in DONE SHALL be ignored.
REQ-028 running SHALL be high exactly when the state is RUN; time_set SHALL be high exactly when remaining != 0. All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, remaining=0, prescaler=0 and button history=0.
REQ-030 After reset, outputs SHALL be finish=0, remaining=0, running=0, time_set=0.
REQ-031 Reset mid-RUN SHALL abort without a finish pulse.

Configuration
REQ-032 Macro COOK_TIMER_ADD_WHILE_RUN_EN SHALL control whether presses are accepted in RUN and PAUSED.
REQ-033 With the macro defined, presses in RUN and PAUSED SHALL be accepted. On a simultaneous tick, the result SHALL be remaining-1+add, saturated. The prescaler SHALL be unaffected.
REQ-034 Without the macro, presses SHALL be accepted only in IDLE and SET and ignored otherwise.

Structure
REQ-035 Package cook_timer_pkg SHALL hold the state enum, SEC_W=13 and the constants ADD_SHORT=10 and ADD_LONG=60.
REQ-036 Sub-module sec_tick SHALL contain the prescaler: inputs clk, rst, en, hold; output tick; parameter CLK_HZ.

Verification (CLK_HZ=4)
REQ-037 Scenario: rst, then one add_10s edge, then heat held high. Required: state RUN; remaining 10 -> 0 over 40 cycles; finish high for exactly 1 cycle after the final tick; running low afterwards.
REQ-038 Scenario: 100 add_60s edges. Required: remaining saturates at 5999 with no wrap.
REQ-039 Scenario: 10 s set, heat high 6 cycles, heat low 20 cycles, heat high again. Required: remaining frozen at 9 while paused; the next tick comes 2 cycles after resume (prescaler held).
REQ-040 Scenario: heat high with remaining=0 in IDLE. Required: finish pulse exactly 1 cycle later.
REQ-041 Scenario: clear asserted together with an add_60s edge during RUN at remaining=5. Required: remaining=0, IDLE, finish never asserted.
REQ-042 Scenario: press during RUN at remaining=20. Required with macro: 30 (29 if the press coincides with a tick). Required without macro: unchanged.
